sram_bus_arbiter: RTL and testbench

//  Shares one SRAM-like bus between the fetch stage's instruction port and the memory

---
 rtl/sram_bus_arbiter_if.sv | 54 +++++
 rtl/sram_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: groups the instruction port, the data port and the shared
// SRAM-like bus of sram_bus_arbiter into one bundle.
//   master : the arbiter's view (drives grants, responses and the bus request)
//   slave  : the environment's view (requesters plus the bus target)
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch stage port
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    // memory stage port
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    // shared bus
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_timeout;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output bus_timeout
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  bus_timeout
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between the instruction fetch port and
// the load/store port, one transaction in flight (IDLE -> ADDR -> DATA).
// A watchdog forces completion of a stalled data phase after TIMEOUT cycles and
// raises the sticky bus_timeout flag.
// Optional: define ARB_ROUND_ROBIN_EN to alternate contended grants; otherwise
// data has fixed priority over inst.
module sram_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                clk,
    input logic                reset,
    sram_bus_arbiter_if.master bus_if
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       owner_q;      // 0 = inst, 1 = data
    logic [7:0] wd_cnt_q;
    logic       grant_inst;
    logic       grant_data;
    logic       expire;

`ifdef ARB_ROUND_ROBIN_EN
    logic       rr_inst_q;    // 1 = inst wins the next contended grant
    logic       contend;

    // arbitration: contended grants alternate, uncontended grants go to the requester
    always_comb begin
        contend    = bus_if.inst_req && bus_if.data_req;
        grant_data = bus_if.data_req && !(contend && rr_inst_q);
        grant_inst = bus_if.inst_req && !grant_data;
    end

    // priority pointer flips only on contended grants
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_inst_q <= 1'b0;
        end else if (state_q == ST_IDLE && contend) begin
            rr_inst_q <= grant_data;
        end
    end
`else
    // arbitration: fixed data-over-inst priority
    always_comb begin
        grant_data = bus_if.data_req;
        grant_inst = bus_if.inst_req && !bus_if.data_req;
    end
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, grant pulses, bus request and response routing
    always_comb begin
        state_d             = state_q;
        expire              = 1'b0;
        bus_if.inst_addr_ok = 1'b0;
        bus_if.data_addr_ok = 1'b0;
        bus_if.inst_data_ok = 1'b0;
        bus_if.data_data_ok = 1'b0;
        bus_if.inst_rdata   = '0;
        bus_if.data_rdata   = '0;
        bus_if.bus_req      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus_if.inst_addr_ok = grant_inst;
                bus_if.data_addr_ok = grant_data;
                if (grant_inst || grant_data) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus_if.bus_req = 1'b1;
                if (bus_if.bus_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // a real response in the expiry cycle takes precedence over the watchdog
                if (bus_if.bus_data_ok || wd_cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_IDLE;
                    expire  = !bus_if.bus_data_ok;
                    if (owner_q) begin
                        bus_if.data_data_ok = 1'b1;
                        bus_if.data_rdata   = bus_if.bus_data_ok ? bus_if.bus_rdata : '0;
                    end else begin
                        bus_if.inst_data_ok = 1'b1;
                        bus_if.inst_rdata   = bus_if.bus_data_ok ? bus_if.bus_rdata : '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // owner and bus fields are captured only at grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q          <= 1'b0;
            bus_if.bus_wr    <= 1'b0;
            bus_if.bus_size  <= 2'd0;
            bus_if.bus_addr  <= '0;
            bus_if.bus_wdata <= '0;
        end else if (state_q == ST_IDLE && (grant_inst || grant_data)) begin
            owner_q <= grant_data;
            if (grant_data) begin
                bus_if.bus_wr    <= bus_if.data_wr;
                bus_if.bus_size  <= bus_if.data_size;
                bus_if.bus_addr  <= bus_if.data_addr;
                bus_if.bus_wdata <= bus_if.data_wdata;
            end else begin
                bus_if.bus_wr    <= 1'b0;
                bus_if.bus_size  <= 2'd2;
                bus_if.bus_addr  <= bus_if.inst_addr;
                bus_if.bus_wdata <= '0;
            end
        end
    end

    // watchdog: cleared on address acceptance, counts every DATA cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= 8'd0;
        end else if (state_q == ST_ADDR && bus_if.bus_addr_ok) begin
            wd_cnt_q <= 8'd0;
        end else if (state_q == ST_DATA) begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
        end
    end

    // sticky watchdog-expiry flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_if.bus_timeout <= 1'b0;
        end else if (expire) begin
            bus_if.bus_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed and randomized transactions against a
// transaction-level model of grant order, phase timing, response routing and
// the watchdog. Compile with the same ARB_ROUND_ROBIN_EN setting as the design.
module tb_sram_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus_if(bif)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // model state
    logic        m_timeout = 1'b0;
    logic        m_rr_inst = 1'b0;
    // pending requests and their fields, as the requesters hold them
    logic        i_req   = 1'b0;
    logic [31:0] i_addr  = '0;
    logic        d_req   = 1'b0;
    logic        d_wr    = 1'b0;
    logic [1:0]  d_size  = 2'd0;
    logic [31:0] d_addr  = '0;
    logic [31:0] d_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_oks(input string tag, input logic ia, input logic da,
                           input logic id, input logic dd);
        chk({tag, ".inst_addr_ok"}, 32'(bif.inst_addr_ok), 32'(ia));
        chk({tag, ".data_addr_ok"}, 32'(bif.data_addr_ok), 32'(da));
        chk({tag, ".inst_data_ok"}, 32'(bif.inst_data_ok), 32'(id));
        chk({tag, ".data_data_ok"}, 32'(bif.data_data_ok), 32'(dd));
    endtask

    // one arbitrated transaction: grant, addr_lat stall cycles in ADDR,
    // response after resp_lat DATA cycles (resp_lat > TO means no response)
    task automatic txn(input int addr_lat, input int resp_lat, input logic [31:0] resp_data);
        logic        win_data;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        done;
        logic        expired;
        int          c;

        win_data = d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            win_data  = !m_rr_inst;
            m_rr_inst = win_data;
        end
`endif
        e_wr    = win_data ? d_wr    : 1'b0;
        e_size  = win_data ? d_size  : 2'd2;
        e_addr  = win_data ? d_addr  : i_addr;
        e_wdata = d_wdata;

        // grant cycle (stray bus_data_ok in IDLE must be ignored)
        @(negedge clk);
        bif.inst_req    = i_req;
        bif.inst_addr   = i_addr;
        bif.data_req    = d_req;
        bif.data_wr     = d_wr;
        bif.data_size   = d_size;
        bif.data_addr   = d_addr;
        bif.data_wdata  = d_wdata;
        bif.bus_addr_ok = 1'b0;
        bif.bus_data_ok = 1'($urandom_range(0, 1));
        bif.bus_rdata   = $urandom;
        #1;
        chk_oks("grant", !win_data, win_data, 1'b0, 1'b0);
        chk("grant.bus_req", 32'(bif.bus_req), 32'd0);
        chk("grant.bus_timeout", 32'(bif.bus_timeout), 32'(m_timeout));
        if (win_data) d_req = 1'b0;
        else          i_req = 1'b0;

        // address phase: winner drops and scrambles its request
        for (int k = 0; k <= addr_lat; k++) begin
            @(negedge clk);
            if (win_data) begin
                bif.data_req   = 1'b0;
                bif.data_wr    = 1'($urandom);
                bif.data_size  = 2'($urandom);
                bif.data_addr  = $urandom;
                bif.data_wdata = $urandom;
            end else begin
                bif.inst_req  = 1'b0;
                bif.inst_addr = $urandom;
            end
            bif.bus_addr_ok = (k == addr_lat);
            bif.bus_data_ok = 1'($urandom_range(0, 1));
            bif.bus_rdata   = $urandom;
            #1;
            chk_oks("addr", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("addr.bus_req", 32'(bif.bus_req), 32'd1);
            chk("addr.bus_wr", 32'(bif.bus_wr), 32'(e_wr));
            chk("addr.bus_size", 32'(bif.bus_size), 32'(e_size));
            chk("addr.bus_addr", bif.bus_addr, e_addr);
            if (win_data) chk("addr.bus_wdata", bif.bus_wdata, e_wdata);
        end

        // data phase
        done = 1'b0;
        c    = 0;
        while (!done) begin
            @(negedge clk);
            bif.bus_addr_ok = 1'b0;
            expired = 1'b0;
            if (resp_lat <= TO && c == resp_lat) begin
                bif.bus_data_ok = 1'b1;
                bif.bus_rdata   = resp_data;
                #1;
                chk_oks("resp", 1'b0, 1'b0, !win_data, win_data);
                chk("resp.rdata", win_data ? bif.data_rdata : bif.inst_rdata, resp_data);
                done = 1'b1;
            end else if (c == TO) begin
                bif.bus_data_ok = 1'b0;
                bif.bus_rdata   = $urandom;
                #1;
                chk_oks("wdog", 1'b0, 1'b0, !win_data, win_data);
                chk("wdog.rdata", win_data ? bif.data_rdata : bif.inst_rdata, 32'd0);
                expired = 1'b1;
                done    = 1'b1;
            end else begin
                bif.bus_data_ok = 1'b0;
                bif.bus_rdata   = $urandom;
                #1;
                chk_oks("wait", 1'b0, 1'b0, 1'b0, 1'b0);
                chk("wait.bus_req", 32'(bif.bus_req), 32'd0);
            end
            chk("data.bus_timeout", 32'(bif.bus_timeout), 32'(m_timeout));
            if (expired) m_timeout = 1'b1;
            c++;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bif.inst_req    = 1'b0;
        bif.data_req    = 1'b0;
        bif.bus_addr_ok = 1'b0;
        bif.bus_data_ok = 1'($urandom_range(0, 1));
        bif.bus_rdata   = $urandom;
        #1;
        chk_oks("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle.bus_req", 32'(bif.bus_req), 32'd0);
        chk("idle.bus_timeout", 32'(bif.bus_timeout), 32'(m_timeout));
    endtask

    task automatic raise_inst();
        if (!i_req) begin
            i_req  = 1'b1;
            i_addr = $urandom;
        end
    endtask

    task automatic raise_data();
        if (!d_req) begin
            d_req   = 1'b1;
            d_wr    = 1'($urandom);
            d_size  = 2'($urandom_range(0, 2));
            d_addr  = $urandom;
            d_wdata = $urandom;
        end
    endtask

    initial begin
        bif.inst_req    = 1'b0;
        bif.inst_addr   = '0;
        bif.data_req    = 1'b0;
        bif.data_wr     = 1'b0;
        bif.data_size   = 2'd0;
        bif.data_addr   = '0;
        bif.data_wdata  = '0;
        bif.bus_addr_ok = 1'b0;
        bif.bus_data_ok = 1'b0;
        bif.bus_rdata   = '0;

        // reset values
        @(negedge clk);
        #1;
        chk_oks("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.bus_req", 32'(bif.bus_req), 32'd0);
        chk("rst.bus_wr", 32'(bif.bus_wr), 32'd0);
        chk("rst.bus_size", 32'(bif.bus_size), 32'd0);
        chk("rst.bus_addr", bif.bus_addr, 32'd0);
        chk("rst.bus_wdata", bif.bus_wdata, 32'd0);
        chk("rst.inst_rdata", bif.inst_rdata, 32'd0);
        chk("rst.data_rdata", bif.data_rdata, 32'd0);
        chk("rst.bus_timeout", 32'(bif.bus_timeout), 32'd0);
        reset = 1'b0;
        idle_cycle();

        // single fetch, minimum latency
        i_req  = 1'b1;
        i_addr = 32'hbfc0_0000;
        txn(0, 0, 32'h2402_0001);

        // contended: store granted first, fetch follows
        i_req   = 1'b1;
        i_addr  = 32'hbfc0_0004;
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_size  = 2'd2;
        d_addr  = 32'h8000_1000;
        d_wdata = 32'hdead_beef;
        txn(0, 1, 32'h1111_2222);
        txn(0, 0, 32'h3333_4444);

        // both held for four transactions
        for (int n = 0; n < 4; n++) begin
            raise_inst();
            raise_data();
            txn(0, 0, $urandom);
        end
        while (i_req || d_req) txn(1, 0, $urandom);

        // long address stall
        d_req   = 1'b1;
        d_wr    = 1'b0;
        d_size  = 2'd1;
        d_addr  = 32'h0000_2002;
        txn(5, 2, 32'h5555_aaaa);

        // response in the expiry cycle wins, no timeout flag
        raise_inst();
        txn(0, TO, 32'h7777_0000);
        idle_cycle();

        // watchdog expiry, then sticky flag
        raise_inst();
        txn(1, TO + 1, 32'h0);
        idle_cycle();
        idle_cycle();

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!i_req && !d_req) begin
                case ($urandom_range(1, 3))
                    1:       raise_inst();
                    2:       raise_data();
                    default: begin raise_inst(); raise_data(); end
                endcase
            end else if ($urandom_range(0, 1) == 1) begin
                raise_inst();
                raise_data();
            end
            txn($urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom);
        end
        while (i_req || d_req) txn(0, $urandom_range(0, TO), $urandom);
        idle_cycle();

        // reset during DATA abandons the transaction
        @(negedge clk);
        bif.inst_req    = 1'b1;
        bif.inst_addr   = 32'h1234_5678;
        bif.bus_data_ok = 1'b0;
        #1;
        chk("mrst.grant", 32'(bif.inst_addr_ok), 32'd1);
        @(negedge clk);
        bif.inst_req    = 1'b0;
        bif.bus_addr_ok = 1'b1;
        #1;
        chk("mrst.bus_req", 32'(bif.bus_req), 32'd1);
        @(negedge clk);
        bif.bus_addr_ok = 1'b0;
        #1;
        chk_oks("mrst.data", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        m_timeout = 1'b0;
        m_rr_inst = 1'b0;
        #1;
        chk_oks("mrst.inrst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst.inrst.bus_req", 32'(bif.bus_req), 32'd0);
        chk("mrst.inrst.bus_addr", bif.bus_addr, 32'd0);
        chk("mrst.inrst.bus_timeout", 32'(bif.bus_timeout), 32'd0);
        @(negedge clk);
        reset           = 1'b0;
        bif.bus_data_ok = 1'b1;
        bif.bus_rdata   = 32'hbad0_bad0;
        #1;
        chk_oks("mrst.stray", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst.stray.bus_req", 32'(bif.bus_req), 32'd0);
        idle_cycle();
        i_req  = 1'b1;
        i_addr = 32'hbfc0_0000;
        txn(0, 0, 32'h2402_0001);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
